raw_comb_serializer: RTL
========================

// Module: raw_comb_serializer
// PURPOSE
//   Downstream neighbour of the 5-stream raw combiner, in the bus_clk domain. Takes each
//   80-bit combined beat (5 lanes x 16-bit sample, 5 x 12-bit channel tag) and serializes it
//   into five 32-bit words in SPI bundle layout for the PCIe FIFO. Marks frame ends and counts frames.
//   Checks channel-tag continuity and flags misaligned streams.
// PARAMETERS
//   N_LANES     5    lanes per combined beat (streams)
//   DW          16   sample width per lane
//   CW          12   channel tag width per lane
//   CH_PER_LANE 32   channels multiplexed per stream (RHD2132)
// PORTS
//   bus_clk      in   1       single clock; all logic on rising edge
//   reset        in   1       asynchronous, active-high reset
//   s_valid      in   1       combined beat valid (from combiner m_axis_tvalid)
//   s_ready      out  1       beat accepted when s_valid && s_ready
//   s_data       in   80      {lane4..lane0} samples, lane k = s_data[16k+15:16k]
//   s_ch         in   60      {lane4..lane0} tags, lane k = s_ch[12k+11:12k]
//   m_valid      out  1       output word valid
//   m_ready      in   1       downstream (PCIe FIFO) ready; transfer on m_valid && m_ready
//   m_data       out  32      {3'b0, ch[11:0], 1'b0, sample[15:0]}: ch in [28:17], sample in [15:0]
//   m_last       out  1       high on the word whose ch == N_LANES*CH_PER_LANE-1 (159)
//   frame_cnt    out  32      completed frames (m_last handshakes), wraps 2^32-1 -> 0
//   ch_err       out  1       one-cycle pulse on a continuity/alignment violation of an accepted beat
//   ch_err_flag  out  1       sticky copy of ch_err, cleared only by reset
// BEHAVIOUR
//   Reset (async assert, sync release): s_ready=0 while reset high, then 1; m_valid=0, m_last=0,
//     m_data=0, frame_cnt=0, ch_err=0, ch_err_flag=0, lane index=0, holding regs=0, exp_ch invalid.
//   Datapath: holding register captures s_data/s_ch on accept; lane index 0..N_LANES-1 selects the
//     output lane. Output registered: beat accepted at edge t -> lane0 word on m_data after edge t,
//     lanes emitted in order 0,1,2,3,4, one per m_valid&&m_ready handshake.
//   Handshake: m_valid stays high, m_data stable while m_ready low (AXI-S rules). Lane index
//     advances only on output handshake. s_ready = !m_valid || (idx==N_LANES-1 && m_ready), so a
//     new beat loads in the same cycle the last lane leaves -> 100% throughput, no bubble.
//   States: IDLE (m_valid=0, s_ready=1) -> on accept -> EMIT(idx=0). EMIT: handshake with
//     idx<4 -> idx+1; handshake with idx==4 -> EMIT(idx=0) if s_valid else IDLE.
//   m_last: combinational from the current output ch tag == 159; frame_cnt += 1 on handshake of
//     that word only. Frame_cnt wraps without flag.
//   Channel checks at accept, on s_ch: (a) alignment: ch_k == ch_0 + 32*k for k=1..4;
//     (b) continuity: ch_0 == exp_ch when exp_ch valid; exp_ch <= (ch_0+1) mod 32 after every
//     accept. First beat after reset only sets exp_ch. Violation -> ch_err high the cycle after
//     accept, ch_err_flag set; data is still forwarded unchanged, exp_ch resyncs to received ch_0+1.
//   Simultaneous: load of new beat and last-lane handshake in one cycle is legal and required.
//   Tags wider than used: bits above 7 of ch compared in full (12-bit arithmetic, no truncation).
//   Reset mid-operation: in-flight beat and partially emitted lanes are discarded; no m_last.
// STRUCTURE
//   Shared package xike_pkg: XIKE_N_LANES=5, XIKE_DW=16, XIKE_CW=12, XIKE_CH_PER_LANE=32,
//     XIKE_CH_LSB=17 / XIKE_CH_MSB=28 (bundle field positions), function pack_bundle(ch, sample).
//   One sub-module is natural: raw_ch_checker (alignment + continuity, outputs ch_err pulse);
//     serializer FSM, lane mux, frame counter stay in the top.
// TESTING
//   1) Reset, one beat data={16'h0004,16'h0003,16'h0002,16'h0001,16'h0000}, ch={128,96,64,32,0},
//      m_ready=1 -> m_data 0x00000000,0x00400001,0x00800002,0x00C00003,0x01000004 on 5 cycles.
//   2) Stream 32 beats ch_0=0..31, s_valid and m_ready held 1 -> 160 words back-to-back, no gap,
//      m_last only on ch=159 words, frame_cnt=1, ch_err never high.
//   3) m_ready toggled 1010... mid-beat -> m_data/m_valid stable while low, s_ready low until
//      lane4 handshakes, no word lost or duplicated (scoreboard).
//   4) Inject lane2 ch=65 with ch_0=0 -> ch_err pulses once 1 cycle after accept, ch_err_flag=1,
//      words still output with ch 65; skip ch_0 5->7 -> second pulse, exp_ch=8.
//   5) Assert reset while idx==2 -> m_valid=0, frame_cnt=0, ch_err_flag=0 immediately; next beat
//      starts at lane0 and is not checked for continuity.
//   6) Preload frame_cnt path: 2^32 frames forced via testbench force -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/xike_pkg.sv
// Shared constants, types and bundle packing for the raw combiner / serializer path.
package xike_pkg;

  localparam int unsigned XIKE_N_LANES     = 5;
  localparam int unsigned XIKE_DW          = 16;
  localparam int unsigned XIKE_CW          = 12;
  localparam int unsigned XIKE_CH_PER_LANE = 32;
  localparam int unsigned XIKE_CH_LSB      = 17;
  localparam int unsigned XIKE_CH_MSB      = 28;
  localparam int unsigned XIKE_WORD_W      = 32;
  localparam int unsigned XIKE_IDX_W       = 3;

  typedef logic [XIKE_CW-1:0] ch_t;
  typedef logic [XIKE_DW-1:0] smp_t;

  localparam ch_t XIKE_LAST_CH = ch_t'(XIKE_N_LANES * XIKE_CH_PER_LANE - 1);

  // SPI bundle word: ch tag in [28:17], sample in [15:0]
  typedef struct packed {
    logic [2:0] rsvd;
    ch_t        ch;
    logic       gap;
    smp_t       sample;
  } bundle_t;

  typedef enum logic [0:0] {
    SER_IDLE = 1'b0,
    SER_EMIT = 1'b1
  } ser_state_t;

  function automatic logic [XIKE_WORD_W-1:0] pack_bundle(input ch_t ch, input smp_t sample);
    bundle_t b;
    b.rsvd   = 3'b000;
    b.ch     = ch;
    b.gap    = 1'b0;
    b.sample = sample;
    return b;
  endfunction

endpackage

// File: rtl/raw_ch_checker.sv
// Channel-tag alignment and continuity checker for accepted combined beats.
module raw_ch_checker
  import xike_pkg::*;
(
  input  logic                          bus_clk,
  input  logic                          reset,
  input  logic                          accept,
  input  logic [XIKE_N_LANES*XIKE_CW-1:0] ch,
  output logic                          ch_err,
  output logic                          ch_err_flag
);

  ch_t  exp_ch;
  logic exp_vld;
  logic align_bad;
  logic cont_bad;

  // Full 12-bit comparisons; lane k must carry ch_0 + 32*k
  always_comb begin
    align_bad = 1'b0;
    for (int unsigned k = 1; k < XIKE_N_LANES; k++) begin
      if (ch[k*XIKE_CW +: XIKE_CW] != ch_t'(ch[XIKE_CW-1:0] + ch_t'(k * XIKE_CH_PER_LANE)))
        align_bad = 1'b1;
    end
    cont_bad = exp_vld && (ch[XIKE_CW-1:0] != exp_ch);
  end

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      exp_ch      <= '0;
      exp_vld     <= 1'b0;
      ch_err      <= 1'b0;
      ch_err_flag <= 1'b0;
    end else begin
      ch_err <= accept && (align_bad || cont_bad);
      if (accept && (align_bad || cont_bad))
        ch_err_flag <= 1'b1;
      // Resync to whatever arrived so one glitch reports once
      if (accept) begin
        exp_ch  <= ch_t'(ch[XIKE_CW-1:0] + ch_t'(1)) & ch_t'(XIKE_CH_PER_LANE - 1);
        exp_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/raw_comb_serializer.sv
// Serializes 5-lane combined beats into 32-bit SPI bundle words with frame marking and tag checks.
module raw_comb_serializer
  import xike_pkg::*;
(
  input  logic                            bus_clk,
  input  logic                            reset,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [XIKE_N_LANES*XIKE_DW-1:0] s_data,
  input  logic [XIKE_N_LANES*XIKE_CW-1:0] s_ch,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [XIKE_WORD_W-1:0]          m_data,
  output logic                            m_last,
  output logic [31:0]                     frame_cnt,
  output logic                            ch_err,
  output logic                            ch_err_flag
);

  ser_state_t                      state;
  ser_state_t                      state_nxt;
  logic [XIKE_IDX_W-1:0]           idx;
  logic [XIKE_IDX_W-1:0]           nidx;
  logic [XIKE_N_LANES*XIKE_DW-1:0] hold_data;
  logic [XIKE_N_LANES*XIKE_CW-1:0] hold_ch;
  logic                            accept;
  logic                            out_hs;
  logic                            lane_last;
  ch_t                             nxt_ch;
  smp_t                            nxt_smp;

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) state <= SER_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SER_IDLE: if (s_valid) state_nxt = SER_EMIT;
      SER_EMIT: if (m_ready && lane_last && !s_valid) state_nxt = SER_IDLE;
      default:  state_nxt = SER_IDLE;
    endcase
  end

  // New beat may load in the cycle the last lane leaves
  always_comb begin
    m_valid   = 1'b0;
    s_ready   = 1'b0;
    m_valid   = (state == SER_EMIT);
    lane_last = (idx == XIKE_IDX_W'(XIKE_N_LANES - 1));
    out_hs    = m_valid && m_ready;
    s_ready   = !reset && (!m_valid || (lane_last && m_ready));
    accept    = s_valid && s_ready;
  end

  always_comb begin
    nidx    = idx + XIKE_IDX_W'(1);
    nxt_ch  = '0;
    nxt_smp = '0;
    for (int unsigned k = 0; k < XIKE_N_LANES; k++) begin
      if (nidx == XIKE_IDX_W'(k)) begin
        nxt_ch  = hold_ch[k*XIKE_CW +: XIKE_CW];
        nxt_smp = hold_data[k*XIKE_DW +: XIKE_DW];
      end
    end
  end

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      hold_data <= '0;
      hold_ch   <= '0;
      idx       <= '0;
      m_data    <= '0;
      m_last    <= 1'b0;
    end else if (accept) begin
      hold_data <= s_data;
      hold_ch   <= s_ch;
      idx       <= '0;
      m_data    <= pack_bundle(s_ch[XIKE_CW-1:0], s_data[XIKE_DW-1:0]);
      m_last    <= (s_ch[XIKE_CW-1:0] == XIKE_LAST_CH);
    end else if (out_hs) begin
      if (lane_last) begin
        idx    <= '0;
        m_last <= 1'b0;
      end else begin
        idx    <= nidx;
        m_data <= pack_bundle(nxt_ch, nxt_smp);
        m_last <= (nxt_ch == XIKE_LAST_CH);
      end
    end
  end

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset)                frame_cnt <= '0;
    else if (out_hs && m_last) frame_cnt <= frame_cnt + 32'd1;
  end

  raw_ch_checker u_checker (
    .bus_clk     (bus_clk),
    .reset       (reset),
    .accept      (accept),
    .ch          (s_ch),
    .ch_err      (ch_err),
    .ch_err_flag (ch_err_flag)
  );

endmodule
